// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: encodings, constants and stage payloads.
package cpu_pkg;

  localparam int unsigned CPU_PC_W    = 64;
  localparam int unsigned CPU_INSTR_W = 32;

  // ARM NOP; the only instruction value a bubble may carry
  localparam logic [31:0] NOP = 32'hD503201F;

  // Sequential fetch step in bytes
  localparam int unsigned PC_INC = 4;

  // IF/ID payload seen by decode and the hazard unit
  typedef struct packed {
    logic [CPU_PC_W-1:0]    pc;
    logic [CPU_INSTR_W-1:0] instr;
    logic                   valid;
  } if_id_t;

endpackage

// File: rtl/en_reg.sv
// Enabled register with async reset and synchronous clear (clear wins over enable).
module en_reg #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold when enable is low; clear loads CLR_VAL regardless of enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        PC_W     = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
);

  localparam int unsigned IFID_W = PC_W + INSTR_W + 1;
  localparam logic [IFID_W-1:0] IFID_RST = {PC_W'(0), INSTR_W'(NOP), 1'b0};

  logic              w_en;
  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_next;
  logic [IFID_W-1:0] w_if_id_d;
  logic [IFID_W-1:0] w_if_id_q;

  // Redirect overrides a stall; otherwise stall freezes both registers
  assign w_en      = ~stall | redirect;
  // Targets are word aligned: drop the two low address bits
  assign w_target  = redirect_pc & ~PC_W'(3);
  // Next PC: redirect target or sequential, wrapping modulo 2^PC_W
  assign w_pc_next = redirect ? w_target : w_pc + PC_W'(PC_INC);
  assign w_if_id_d = {w_pc, imem_data, 1'b1};

  en_reg #(
    .W       (PC_W),
    .RST_VAL (RESET_PC),
    .CLR_VAL ('0)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_en),
    .i_clr (1'b0),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  // Redirect clears IF/ID to a bubble, discarding the wrong-path fetch
  en_reg #(
    .W       (IFID_W),
    .RST_VAL (IFID_RST),
    .CLR_VAL (IFID_RST)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_en),
    .i_clr (redirect),
    .i_d   (w_if_id_d),
    .o_q   (w_if_id_q)
  );

  assign imem_addr   = w_pc;
  assign if_id_pc    = w_if_id_q[IFID_W-1 -: PC_W];
  assign if_id_instr = w_if_id_q[INSTR_W:1];
  assign if_id_valid = w_if_id_q[0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'hD503201F;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] salt;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_v;

  fetch_stage #(.PC_W(64), .INSTR_W(32), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h8B000000 + 32'(a >> 2);
  endfunction

  // Combinational instruction memory
  assign imem_data = mem_word(imem_addr) ^ salt;

  task automatic model_reset();
    m_pc = RPC; m_ipc = 64'h0; m_instr = NOP_W; m_v = 1'b0;
  endtask

  // Apply inputs for one edge, advance the model, sample 1 time unit after the edge
  task automatic step(input logic s, input logic r, input logic [63:0] t);
    stall = s; redirect = r; redirect_pc = t;
    if (r) begin
      m_pc = {t[63:2], 2'b00}; m_ipc = 64'h0; m_instr = NOP_W; m_v = 1'b0;
    end else if (!s) begin
      m_ipc = m_pc; m_instr = mem_word(m_pc) ^ salt; m_v = 1'b1; m_pc = m_pc + 64'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; salt = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; salt = '0;
    #3;
    vectors++;
    if ({imem_addr, if_id_pc, if_id_instr, if_id_valid} !== {RPC, 64'h0, NOP_W, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got addr=%h pc=%h instr=%h v=%b exp addr=%h pc=0 instr=%h v=0",
               imem_addr, if_id_pc, if_id_instr, if_id_valid, RPC, NOP_W);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_run();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      vectors++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== {64'(4 * i), 32'h8B000000 + 32'(i), 1'b1}) begin
        miscompares++;
        $display("FAIL run_edge%0d: got pc=%h instr=%h v=%b exp pc=%h instr=%h v=1",
                 i, if_id_pc, if_id_instr, if_id_valid, 64'(4 * i), 32'h8B000000 + 32'(i));
      end
    end
    vectors++;
    if (imem_addr !== 64'd16) begin
      miscompares++;
      $display("FAIL run_addr: got %h exp 16", imem_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0);
      vectors++;
      if ({imem_addr, if_id_pc, if_id_valid} !== {64'd8, 64'd4, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got addr=%h pc=%h v=%b exp addr=8 pc=4 v=1",
                 i, imem_addr, if_id_pc, if_id_valid);
      end
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if ({imem_addr, if_id_pc} !== {64'd12, 64'd8}) begin
      miscompares++;
      $display("FAIL stall_resume: got addr=%h pc=%h exp addr=c pc=8", imem_addr, if_id_pc);
    end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b1, 64'h100);
    vectors++;
    if ({if_id_valid, if_id_instr, imem_addr, if_id_pc} !== {1'b0, NOP_W, 64'h100, 64'h0}) begin
      miscompares++;
      $display("FAIL redirect_bubble: got v=%b instr=%h addr=%h pc=%h exp v=0 instr=%h addr=100 pc=0",
               if_id_valid, if_id_instr, imem_addr, if_id_pc, NOP_W);
    end
    step(1'b0, 1'b0, '0);
    vectors++;
    if ({if_id_pc, if_id_valid, if_id_instr} !== {64'h100, 1'b1, mem_word(64'h100)}) begin
      miscompares++;
      $display("FAIL redirect_target: got pc=%h v=%b instr=%h exp pc=100 v=1 instr=%h",
               if_id_pc, if_id_valid, if_id_instr, mem_word(64'h100));
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 64'h203);
    vectors++;
    if ({imem_addr, if_id_valid, if_id_instr} !== {64'h200, 1'b0, NOP_W}) begin
      miscompares++;
      $display("FAIL redirect_stall: got addr=%h v=%b instr=%h exp addr=200 v=0 instr=%h",
               imem_addr, if_id_valid, if_id_instr, NOP_W);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, '0);
    vectors++;
    if ({imem_addr, if_id_pc, if_id_valid} !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got addr=%h pc=%h v=%b exp addr=0 pc=fffffffffffffffc v=1",
               imem_addr, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 64'h40);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({imem_addr, if_id_pc, if_id_instr, if_id_valid} !== {RPC, 64'h0, NOP_W, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got addr=%h pc=%h instr=%h v=%b exp addr=%h pc=0 instr=%h v=0",
               imem_addr, if_id_pc, if_id_instr, if_id_valid, RPC, NOP_W);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b0, '0);
    vectors++;
    if ({if_id_pc, if_id_valid, imem_addr} !== {RPC, 1'b1, RPC + 64'd4}) begin
      miscompares++;
      $display("FAIL post_reset_fetch: got pc=%h v=%b addr=%h exp pc=%h v=1 addr=%h",
               if_id_pc, if_id_valid, imem_addr, RPC, RPC + 64'd4);
    end
  endtask

  task automatic test_random();
    logic s, r;
    logic [63:0] t;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      t = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) t[63:12] = '0;
      if ($urandom_range(0, 15) == 0) salt = $urandom();
      step(s, r, t);
      vectors++;
      if ({imem_addr, if_id_pc, if_id_instr, if_id_valid} !== {m_pc, m_ipc, m_instr, m_v}) begin
        miscompares++;
        $display("FAIL random%0d: got addr=%h pc=%h instr=%h v=%b exp addr=%h pc=%h instr=%h v=%b",
                 i, imem_addr, if_id_pc, if_id_instr, if_id_valid, m_pc, m_ipc, m_instr, m_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
